// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS core to Avalon-MM bridge.
// Imported by the bridge top and its wait timer.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DATA,
    ST_COMMIT,
    ST_HALTED,
    ST_ERROR
  } bridge_state_t;

  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_bridge_bus_wait_timer.sv
// Counts stalled cycles of the pending bus request and flags a timeout
// on the stall cycle that brings the count up to MAX_WAIT.
module bus_wait_timer #(
  parameter int MAX_WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic waitrequest,
  output logic timeout
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;
  localparam logic [CW-1:0] SAT =
    (MAX_WAIT > 0) ? CW'(MAX_WAIT) : '1;

  logic [CW-1:0] cnt;
  logic          stall;
  logic          done;

  assign stall = req && waitrequest;
  assign done  = req && !waitrequest;

  assign timeout = (MAX_WAIT > 0) && stall && (cnt == LAST);

  // Stall counter: cleared on completion, saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (done) begin
      cnt <= '0;
    end else if (stall && (cnt != SAT)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mips_bus_bridge.sv
// Serialises the core's fetch and data ports onto one Avalon-MM master
// and steps the core one instruction per cpu_clock_enable pulse.
module mips_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_instr_address,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  input  logic        cpu_active,
  output logic [31:0] cpu_instr_readdata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clock_enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        bus_error
);

  bridge_state_t state, next;

  logic [31:0] instr_q;
  logic [31:0] data_q;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic        ce;
  logic        cap_i;
  logic        cap_d;
  logic        set_err;
  logic        timeout;

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .req         (avm_read | avm_write),
    .waitrequest (avm_waitrequest),
    .timeout     (timeout)
  );

  // State, capture registers and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      instr_q   <= '0;
      data_q    <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= next;
      if (cap_i)   instr_q   <= avm_readdata;
      if (cap_d)   data_q    <= avm_readdata;
      if (set_err) bus_error <= 1'b1;
    end
  end

  // Next state, bus request and commit strobe for the current state.
  always_comb begin
    next    = state;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = '0;
    ce      = 1'b0;
    cap_i   = 1'b0;
    cap_d   = 1'b0;
    set_err = 1'b0;
    unique case (state)
      ST_FETCH: begin
        if (!cpu_active) begin
          next = ST_HALTED;
        end else begin
          rd   = 1'b1;
          addr = cpu_instr_address;
          if (timeout) begin
            next    = ST_ERROR;
            set_err = 1'b1;
          end else if (!avm_waitrequest) begin
            cap_i = 1'b1;
            next  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cpu_data_read || cpu_data_write) begin
          addr = cpu_data_address;
          if (cpu_data_read) begin
            rd = 1'b1;
          end else begin
            wr    = 1'b1;
            wdata = cpu_data_writedata;
          end
          if (timeout) begin
            next    = ST_ERROR;
            set_err = 1'b1;
          end else if (!avm_waitrequest) begin
            cap_d = cpu_data_read;
            next  = ST_COMMIT;
          end
        end else begin
          ce   = 1'b1;
          next = ST_FETCH;
        end
      end
      ST_COMMIT: begin
        ce   = 1'b1;
        next = ST_FETCH;
      end
      ST_HALTED: next = ST_HALTED;
      ST_ERROR:  next = ST_ERROR;
      default:   next = ST_FETCH;
    endcase
  end

  assign cpu_instr_readdata = instr_q;
  assign cpu_data_readdata  = data_q;

  // Reset lets the core clear its register file and kills any request.
  assign cpu_clock_enable = ce | reset;
  assign avm_read         = rd & ~reset;
  assign avm_write        = wr & ~reset;
  assign avm_address      = addr & ~32'h3;
  assign avm_writedata    = wdata;
  assign avm_byteenable   = BYTEEN_WORD;

endmodule
